// File: rtl/demux_pkg.sv
// demux_pkg: shared request type, state encoding and widths for the demux sequencer
package demux_pkg;
    localparam int DEST_W = 2;
    localparam int NUM_OUT = 4;
    typedef struct packed {
        logic              data;
        logic [DEST_W-1:0] dest;
    } demux_req_t;
    typedef enum logic { IDLE, DRIVE } state_t;
endpackage

// File: rtl/demux_sel_sequencer_fifo.sv
// demux_req_fifo: circular request buffer; pushes when full and pops when empty are ignored
module demux_req_fifo
    import demux_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  demux_req_t       din,
    input  logic             pop,
    output demux_req_t       dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    demux_req_t       mem [DEPTH];
    logic [PTR_W-1:0] wp, rp;
    logic             do_push, do_pop;
    assign full    = count == CNT_W'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    // Power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + PTR_W'(do_push);
            rp    <= rp + PTR_W'(do_pop);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer: replays queued {data, dest} requests onto demux in/sel for HOLD_CYCLES each
module demux_sel_sequencer
    import demux_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD_CYCLES = 10,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_data,
    input  logic [DEST_W-1:0] req_dest,
    output logic              demux_in,
    output logic [DEST_W-1:0] demux_sel,
    output logic              active,
    output logic [CNT_W-1:0]  fifo_count
);
    localparam int TMR_W = $clog2(HOLD_CYCLES) + 1;
    state_t           state;
    logic [TMR_W-1:0] timer;
    demux_req_t       req, head;
    logic             full, empty, pop;
    assign req       = {req_data, req_dest};
    assign req_ready = !full;
    assign active    = state == DRIVE;
    // Back-to-back: the final DRIVE cycle pops the next entry with no idle gap
    assign pop       = !empty && (state == IDLE || timer == '0);
    demux_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid),
        .din   (req),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
    // demux_sel is left untouched on return to IDLE so the select lines never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            demux_in  <= 1'b0;
            demux_sel <= '0;
        end else if (pop) begin
            state     <= DRIVE;
            timer     <= TMR_W'(HOLD_CYCLES - 1);
            demux_in  <= head.data;
            demux_sel <= head.dest;
        end else if (state == DRIVE && timer != '0) begin
            timer <= timer - TMR_W'(1);
        end else begin
            state    <= IDLE;
            demux_in <= 1'b0;
        end
    end
endmodule

// File: tb/tb_demux_sel_sequencer.sv
// tb_demux_sel_sequencer: directed checks of the sequencer with HOLD_CYCLES=10 and HOLD_CYCLES=1
module tb_demux_sel_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0, a_data = 1'b0;
    logic [1:0] a_dest = 2'd0;
    logic       a_ready, a_in, a_act;
    logic [1:0] a_sel;
    logic [2:0] a_cnt;
    logic       b_valid = 1'b0, b_data = 1'b0;
    logic [1:0] b_dest = 2'd0;
    logic       b_ready, b_in, b_act;
    logic [1:0] b_sel;
    logic [2:0] b_cnt;

    always #5 clk = ~clk;

    demux_sel_sequencer #(.DEPTH(4), .HOLD_CYCLES(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_data(a_data),
        .req_dest(a_dest), .demux_in(a_in), .demux_sel(a_sel), .active(a_act), .fifo_count(a_cnt)
    );
    demux_sel_sequencer #(.DEPTH(4), .HOLD_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_data(b_data),
        .req_dest(b_dest), .demux_in(b_in), .demux_sel(b_sel), .active(b_act), .fifo_count(b_cnt)
    );

    typedef struct {
        logic       valid;
        logic       data;
        logic [1:0] dest;
        logic       e_in;
        logic [1:0] e_sel;
        logic       e_act;
        int         e_cnt;
    } vec_t;
    vec_t tv[12];

    int checks = 0, errors = 0;
    logic       s_data[8];
    logic [1:0] s_dest[8];
    int         s_at[8];
    int         s_cnt[100];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        foreach (s_cnt[i]) s_cnt[i] = -1;
        foreach (s_at[i]) s_at[i] = -1;
    endtask

    // Entry j must occupy the outputs for cycles 10j..10j+9 after the first pop edge
    task automatic run(input string nm, input int n);
        int p = 0;
        logic acc;
        for (int c = -1; c <= n * 10; c++) begin
            a_valid = p < n && c >= s_at[p];
            a_data  = s_data[p];
            a_dest  = s_dest[p];
            acc = a_valid && a_ready;
            @(posedge clk); #1;
            if (acc) p++;
            if (c >= 0 && c < n * 10) begin
                chk({nm, " active"}, a_act, 1);
                chk({nm, " in"}, a_in, s_data[c / 10]);
                chk({nm, " sel"}, a_sel, s_dest[c / 10]);
            end
            if (c == n * 10) begin
                chk({nm, " end active"}, a_act, 0);
                chk({nm, " end in"}, a_in, 0);
                chk({nm, " end sel"}, a_sel, s_dest[n - 1]);
            end
            if (s_cnt[c + 1] >= 0) begin
                chk({nm, " count"}, a_cnt, s_cnt[c + 1]);
                chk({nm, " ready"}, a_ready, s_cnt[c + 1] != 4);
            end
        end
        a_valid = 1'b0;
        chk({nm, " accepted"}, p, n);
    endtask

    initial begin
        logic [1:0] bs[5] = '{0, 1, 2, 3, 3};
        logic       bi[5] = '{0, 1, 0, 1, 0};
        logic       ba[5] = '{0, 1, 1, 1, 0};
        int         bc[5] = '{1, 1, 1, 0, 0};
        logic [1:0] bd[3] = '{1, 2, 3};
        logic       bdat[3] = '{1, 0, 1};
        tv[0] = '{1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1};
        for (int i = 1; i <= 10; i++) tv[i] = '{1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 0};
        tv[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 0};

        #1;
        chk("reset in", a_in, 0);
        chk("reset sel", a_sel, 0);
        chk("reset active", a_act, 0);
        chk("reset count", a_cnt, 0);
        chk("reset ready", a_ready, 1);
        chk("reset b active", b_act, 0);
        chk("reset b ready", b_ready, 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            a_valid = tv[i].valid;
            a_data  = tv[i].data;
            a_dest  = tv[i].dest;
            @(posedge clk); #1;
            chk($sformatf("single[%0d] in", i), a_in, tv[i].e_in);
            chk($sformatf("single[%0d] sel", i), a_sel, tv[i].e_sel);
            chk($sformatf("single[%0d] active", i), a_act, tv[i].e_act);
            chk($sformatf("single[%0d] count", i), a_cnt, tv[i].e_cnt);
            chk($sformatf("single[%0d] ready", i), a_ready, 1);
        end

        clr();
        s_data[0:4] = '{1, 1, 1, 1, 0};
        s_dest[0:4] = '{0, 1, 2, 3, 0};
        s_cnt[4] = 4; s_cnt[11] = 3; s_cnt[41] = 0;
        run("sweep", 5);

        clr();
        s_data[0:5] = '{1, 0, 1, 0, 1, 1};
        s_dest[0:5] = '{3, 2, 1, 0, 3, 2};
        s_cnt[4] = 4; s_cnt[5] = 4; s_cnt[11] = 3; s_cnt[12] = 4; s_cnt[21] = 3; s_cnt[61] = 0;
        run("backpressure", 6);

        clr();
        s_data[0:3] = '{0, 1, 1, 0};
        s_dest[0:3] = '{1, 3, 0, 2};
        s_at[3] = 10;
        s_cnt[1] = 1; s_cnt[2] = 2; s_cnt[10] = 2; s_cnt[11] = 2; s_cnt[21] = 1; s_cnt[31] = 0;
        run("pushpop", 4);

        for (int c = 0; c < 5; c++) begin
            b_valid = c < 3;
            b_data  = bdat[c % 3];
            b_dest  = bd[c % 3];
            @(posedge clk); #1;
            chk($sformatf("hold1[%0d] sel", c), b_sel, bs[c]);
            chk($sformatf("hold1[%0d] in", c), b_in, bi[c]);
            chk($sformatf("hold1[%0d] active", c), b_act, ba[c]);
            chk($sformatf("hold1[%0d] count", c), b_cnt, bc[c]);
        end
        b_valid = 1'b0;

        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1;
            a_data  = 1'b1;
            a_dest  = 2'(k + 1);
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        chk("midreset pre count", a_cnt, 2);
        chk("midreset pre active", a_act, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset in", a_in, 0);
        chk("midreset sel", a_sel, 0);
        chk("midreset active", a_act, 0);
        chk("midreset count", a_cnt, 0);
        chk("midreset ready", a_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            chk($sformatf("postreset[%0d] active", c), a_act, 0);
            chk($sformatf("postreset[%0d] in", c), a_in, 0);
            chk($sformatf("postreset[%0d] count", c), a_cnt, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
